// File: rtl/cut_sweep_if.sv
// cut_sweep_if: host/CUT-side bundle for cut_sweep_ctrl.
//   start, abort  : sweep control from the host
//   cut_x, cut_f  : vector driven to the CUT and its output word
//   busy, done    : sweep status
//   rd_addr/data  : random-access truth-table read port
//   sig           : 16-bit MISR signature (zero when the MISR is not built)
// Modports: master = host/bench side, slave = cut_sweep_ctrl side.
interface cut_sweep_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 10
);

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   cut_x;
  logic [N_OUT-1:0]  cut_f;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   rd_addr;
  logic [N_OUT-1:0]  rd_data;
  logic [15:0]       sig;

  modport master (
    output start, abort, cut_f, rd_addr,
    input  cut_x, busy, done, rd_data, sig
  );

  modport slave (
    input  start, abort, cut_f, rd_addr,
    output cut_x, busy, done, rd_data, sig
  );

endinterface

// File: rtl/cut_sweep_ctrl.sv
// cut_sweep_ctrl: exhaustive input sweep of a small combinational CUT.
// Drives every N_IN-bit vector in ascending order, holds each for SETTLE
// cycles plus one capture cycle, and stores the CUT output word into a
// 2^N_IN-entry truth-table buffer readable through a combinational port.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   bus (slave) start/abort control, cut_x/cut_f CUT connection,
//               busy/done status, rd_addr/rd_data buffer read, sig signature
//
// Build option: define CUT_SWEEP_MISR_EN to add a 16-bit MISR that compacts
// the captured words into bus.sig; otherwise bus.sig is tied to zero.
module cut_sweep_ctrl #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  cut_sweep_if.slave bus
);

  localparam int unsigned      DEPTH    = 1 << N_IN;
  localparam int unsigned      CNT_W    = 4;
  localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]  cut_x_q, cut_x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en;

  logic [N_OUT-1:0] buf_q [DEPTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over both settle expiry and capture
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.abort)         state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus.abort || (vec_q == LAST_VEC)) state_d = ST_IDLE;
        else                                  state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and buffer write strobe
  always_comb begin
    vec_d   = vec_q;
    cut_x_d = cut_x_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort here: abort only matters mid-sweep
        if (bus.start) begin
          vec_d   = '0;
          cut_x_d = '0;
          cnt_d   = CNT_LOAD;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else begin
          wr_en = 1'b1;
          // Stop on the last vector so vec/cut_x never wrap back to zero
          if (vec_q == LAST_VEC) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cut_x_d = vec_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q   <= '0;
      cut_x_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cut_x_q <= cut_x_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Truth-table buffer, one register row per input vector
  for (genvar g = 0; g < DEPTH; g++) begin : g_buf
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        buf_q[g] <= '0;
      end else if (wr_en && (vec_q == N_IN'(g))) begin
        buf_q[g] <= bus.cut_f;
      end
    end
  end

  // Zero-latency read; a same-cycle write is visible from the next cycle
  assign bus.rd_data = buf_q[bus.rd_addr];

  assign bus.cut_x = cut_x_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef CUT_SWEEP_MISR_EN
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  logic [15:0] sig_q, sig_d;
  logic        misr_fb;
  logic        sweep_start;

  assign sweep_start = (state_q == ST_IDLE) && bus.start;

  // MISR: reseed on an accepted start, shift only on capture cycles
  always_comb begin
    misr_fb = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
    sig_d   = sig_q;
    if (sweep_start) begin
      sig_d = MISR_SEED;
    end else if (wr_en) begin
      sig_d = {sig_q[14:0], misr_fb} ^ 16'(bus.cut_f);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = 16'h0000;
`endif

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// tb_cut_sweep_ctrl: directed bench for cut_sweep_ctrl.
// u_dut runs with SETTLE=1 against a selectable CUT model (identity,
// two-cycle-delayed identity, or identity xor a fixed pattern); u_dut3 runs
// with SETTLE=3 against the delayed model. Honours CUT_SWEEP_MISR_EN.
`timescale 1ns/1ps
module tb_cut_sweep_ctrl;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 10;
  localparam logic [N_OUT-1:0] PAT = 10'h3A5;
`ifdef CUT_SWEEP_MISR_EN
  localparam logic [15:0] SEED_EXP = 16'hFFFF;
`else
  localparam logic [15:0] SEED_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cut_mode = 0;

  logic [N_IN-1:0] dly1, dly2, dly31, dly32;

  always #5 clk = ~clk;

  cut_sweep_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus  ();
  cut_sweep_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus3 ();

  cut_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  cut_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // CUT models: two-cycle output delay registers
  always @(posedge clk) begin
    dly1  <= bus.cut_x;
    dly2  <= dly1;
    dly31 <= bus3.cut_x;
    dly32 <= dly31;
  end

  assign bus.cut_f = (cut_mode == 1) ? N_OUT'(dly2) :
                     (cut_mode == 2) ? (N_OUT'(bus.cut_x) ^ PAT) :
                                       N_OUT'(bus.cut_x);
  assign bus3.cut_f = N_OUT'(dly32);

  // Pulse start for one sampling edge; returns at the negedge after that edge
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; cyc counts edges after the start edge
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.rd_addr = '0;
    bus3.start = 1'b0; bus3.abort = 1'b0; bus3.rd_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", bus.done); end
    checks++; if (bus.cut_x !== 3'd0) begin errors++; $display("FAIL rst_cut_x: got %0d expected 0", bus.cut_x); end
    checks++; if (bus.sig !== SEED_EXP) begin errors++; $display("FAIL rst_sig: got %0h expected %0h", bus.sig, SEED_EXP); end
    for (int k = 0; k < 8; k++) begin
      bus.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rst_rd[%0d]: got %0h expected 0", k, bus.rd_data); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [15:0] m;
    cut_mode = 0;
    do_start();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL id_busy: got %0b expected 1", bus.busy); end
    for (int c = 0; c < 16; c++) begin
      checks++; if (bus.cut_x !== N_IN'(c / 2)) begin errors++; $display("FAIL id_cut_x@%0d: got %0d expected %0d", c, bus.cut_x, c / 2); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL id_early_done@%0d: got %0b expected 0", c, bus.done); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL id_end: got done=%0b busy=%0b expected done=1 busy=0", bus.done, bus.busy); end
    checks++; if (bus.cut_x !== 3'd7) begin errors++; $display("FAIL id_cut_x_hold: got %0d expected 7", bus.cut_x); end
    for (int k = 0; k < 8; k++) begin
      bus.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus.rd_data !== N_OUT'(k)) begin errors++; $display("FAIL id_rd[%0d]: got %0h expected %0h", k, bus.rd_data, k); end
    end
    m = 16'hFFFF;
    for (int k = 0; k < 8; k++) m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ 16'(k);
`ifndef CUT_SWEEP_MISR_EN
    m = 16'h0000;
`endif
    checks++; if (bus.sig !== m) begin errors++; $display("FAIL id_sig: got %0h expected %0h", bus.sig, m); end
  endtask

  task automatic test_settle();
    int cyc;
    // SETTLE=3 against a two-cycle-delay CUT: every entry correct, 32 cycles
    @(negedge clk);
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    cyc = 0;
    while (bus3.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL settle3_len: got %0d expected 32", cyc); end
    for (int k = 0; k < 8; k++) begin
      bus3.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus3.rd_data !== N_OUT'(k)) begin errors++; $display("FAIL settle3_rd[%0d]: got %0h expected %0h", k, bus3.rd_data, k); end
    end
    // SETTLE=1 against the same CUT: each entry sees the previous vector
    cut_mode = 1;
    do_start();
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL settle1_len: got %0d expected 16", cyc); end
    for (int k = 1; k < 8; k++) begin
      bus.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus.rd_data !== N_OUT'(k - 1)) begin errors++; $display("FAIL settle1_rd[%0d]: got %0h expected %0h", k, bus.rd_data, k - 1); end
    end
  endtask

  task automatic test_abort();
    int cyc;
    cut_mode = 2;
    do_start();
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL abort_fill_len: got %0d expected 16", cyc); end
    cut_mode = 0;
    do_start();
    repeat (8) @(negedge clk);
    checks++; if (bus.cut_x !== 3'd4) begin errors++; $display("FAIL abort_pre_cut_x: got %0d expected 4", bus.cut_x); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_status: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done); end
    checks++; if (bus.cut_x !== 3'd4) begin errors++; $display("FAIL abort_cut_x: got %0d expected 4", bus.cut_x); end
    for (int k = 0; k < 8; k++) begin
      logic [N_OUT-1:0] e;
      e = (k < 4) ? N_OUT'(k) : (N_OUT'(k) ^ PAT);
      bus.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL abort_rd[%0d]: got %0h expected %0h", k, bus.rd_data, e); end
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done); end
    do_start();
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL abort_rerun_len: got %0d expected 16", cyc); end
    for (int k = 4; k < 8; k++) begin
      bus.rd_addr = N_IN'(k);
      #1;
      checks++; if (bus.rd_data !== N_OUT'(k)) begin errors++; $display("FAIL abort_rerun_rd[%0d]: got %0h expected %0h", k, bus.rd_data, k); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    cut_mode = 0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_sticky_done: got %0b expected 1", bus.done); end
    do_start();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_clr: got %0b expected 0", bus.done); end
    for (int c = 0; c < 16; c++) begin
      bus.start = (c == 2 || c == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_len: got done=%0b busy=%0b expected done=1 busy=0", bus.done, bus.busy); end
    // start and abort together in IDLE: start wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_start_abort: got busy=%0b done=%0b expected 1 0", bus.busy, bus.done); end
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL b2b_sa_len: got %0d expected 16", cyc); end
  endtask

  task automatic test_reset_mid_sweep();
    cut_mode = 2;
    do_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rmid_status: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done); end
    checks++; if (bus.cut_x !== 3'd0) begin errors++; $display("FAIL rmid_cut_x: got %0d expected 0", bus.cut_x); end
    checks++; if (bus.sig !== SEED_EXP) begin errors++; $display("FAIL rmid_sig: got %0h expected %0h", bus.sig, SEED_EXP); end
    for (int k = 0; k < 8; k++) begin
      bus.rd_addr = N_IN'(k);
      #0.5;
      checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rmid_rd[%0d]: got %0h expected 0", k, bus.rd_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_settle();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
